// File: rtl/rf_write_arbiter.sv
// Two-requester write-port arbiter for the register file: one-entry holding
// buffer per requester, round-robin drain into a registered write strobe.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_write_en,
  output logic [15:0]           rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  rf_grant_id,
  input  logic [ADDR_WIDTH-1:0] read_address_0,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  output logic                  hazard_0,
  output logic                  hazard_1,
  output logic                  idle
);

  // Handshake: a request transfers on a rising edge where valid and ready are
  // both high; the requester must hold addr/data stable while valid && !ready.

  logic                  full_0, full_1;
  logic [ADDR_WIDTH-1:0] addr_0, addr_1;
  logic [DATA_WIDTH-1:0] data_0, data_1;
  logic                  last_grant;
  logic                  grant_0, grant_1;
  logic                  accept_0, accept_1;

  // last_grant resets to 1 so the first tie goes to req0.
  always_comb begin
    grant_0 = full_0 && (!full_1 || last_grant);
    grant_1 = full_1 && (!full_0 || !last_grant);
  end

  assign req0_ready = !full_0 || grant_0;
  assign req1_ready = !full_1 || grant_1;
  assign accept_0   = req0_valid && req0_ready;
  assign accept_1   = req1_valid && req1_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_0     <= 1'b0;
      full_1     <= 1'b0;
      addr_0     <= '0;
      addr_1     <= '0;
      data_0     <= '0;
      data_1     <= '0;
      last_grant <= 1'b1;
    end else begin
      if (accept_0) begin
        full_0 <= 1'b1;
        addr_0 <= req0_addr;
        data_0 <= req0_data;
      end else if (grant_0) begin
        full_0 <= 1'b0;
      end
      if (accept_1) begin
        full_1 <= 1'b1;
        addr_1 <= req1_addr;
        data_1 <= req1_data;
      end else if (grant_1) begin
        full_1 <= 1'b0;
      end
      if (grant_0 || grant_1) begin
        last_grant <= grant_1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_en      <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
      rf_grant_id      <= 1'b0;
    end else begin
      rf_write_en <= grant_0 || grant_1;
      if (grant_0) begin
        rf_write_address <= 16'(addr_0);
        rf_write_data    <= data_0;
        rf_grant_id      <= 1'b0;
      end else if (grant_1) begin
        rf_write_address <= 16'(addr_1);
        rf_write_data    <= data_1;
        rf_grant_id      <= 1'b1;
      end
    end
  end

  // A write stays hazardous until the cycle after its strobe, when the
  // register file already holds the new value.
  always_comb begin
    hazard_0 = (full_0 && addr_0 == read_address_0) ||
               (full_1 && addr_1 == read_address_0) ||
               (rf_write_en && rf_write_address[ADDR_WIDTH-1:0] == read_address_0);
    hazard_1 = (full_0 && addr_0 == read_address_1) ||
               (full_1 && addr_1 == read_address_1) ||
               (rf_write_en && rf_write_address[ADDR_WIDTH-1:0] == read_address_1);
  end

  assign idle = !full_0 && !full_1 && !rf_write_en;

endmodule
